// File: rtl/mux2_arbiter_if.sv
// Valid/ready bundle for mux2_arbiter: two requesters in, one registered output out.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface mux2_arbiter_if #(
  parameter int N = 16
);
  logic [N-1:0] D0;
  logic         V0;
  logic         R0;
  logic [N-1:0] D1;
  logic         V1;
  logic         R1;
  logic [N-1:0] Y;
  logic         YV;
  logic         YR;
  logic         S;

  modport master (
    output D0, V0, D1, V1, YR,
    input  R0, R1, Y, YV, S
  );

  modport slave (
    input  D0, V0, D1, V1, YR,
    output R0, R1, Y, YV, S
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin burst arbiter sharing one 2:1 mux between two valid/ready requesters.
// Optional per-requester transfer counters: define MUX2_ARBITER_STATS_EN.
module mux2 #(
  parameter int N = 16
) (
  input  logic         sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  assign y = sel ? b : a;
endmodule

module mux2_arbiter #(
  parameter int N     = 16,
  parameter int BURST = 4
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  mux2_arbiter_if.slave bus
`ifdef MUX2_ARBITER_STATS_EN
  ,
  output logic [31:0]   CNT0,
  output logic [31:0]   CNT1
`endif
);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state, state_nxt;
  logic          prio, prio_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cur, vcur;
  logic          accept, r0, r1, xfer;
  logic [N-1:0]  word_p0;
  logic [N-1:0]  y_p1;
  logic          vld_p1;
  logic          s_p1;

  function automatic state_t pick(input logic p, input logic v0, input logic v1);
    if (p ? v1 : v0) return p ? GNT1 : GNT0;
    else if (p ? v0 : v1) return p ? GNT0 : GNT1;
    else return IDLE;
  endfunction

  // Stage p0: select and handshake against the single-entry output stage
  mux2 #(.N(N)) u_mux (
    .sel (s_p1),
    .a   (bus.D0),
    .b   (bus.D1),
    .y   (word_p0)
  );

  assign accept = !vld_p1 || bus.YR;
  assign r0     = (state == GNT0) && accept;
  assign r1     = (state == GNT1) && accept;
  assign xfer   = (r0 && bus.V0) || (r1 && bus.V1);

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    cnt_nxt   = cnt;
    cur       = (state == GNT1);
    vcur      = cur ? bus.V1 : bus.V0;
    case (state)
      IDLE: begin
        state_nxt = pick(prio, bus.V0, bus.V1);
        cnt_nxt   = '0;
      end
      GNT0, GNT1: begin
        // A withdrawn request ends the grant just like a finished burst.
        if ((xfer && (cnt == LAST)) || !vcur) begin
          prio_nxt  = !cur;
          state_nxt = pick(!cur, bus.V0, bus.V1);
          cnt_nxt   = '0;
        end else if (xfer) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered control, select and output word
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      prio   <= 1'b0;
      cnt    <= '0;
      s_p1   <= 1'b0;
      y_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      cnt   <= cnt_nxt;
      s_p1  <= (state_nxt == GNT1);
      if (xfer) begin
        y_p1   <= word_p0;
        vld_p1 <= 1'b1;
      end else if (vld_p1 && bus.YR) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.R0 = r0;
  assign bus.R1 = r1;
  assign bus.Y  = y_p1;
  assign bus.YV = vld_p1;
  assign bus.S  = s_p1;

`ifdef MUX2_ARBITER_STATS_EN
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      CNT0 <= '0;
      CNT1 <= '0;
    end else begin
      if (r0 && bus.V0 && (CNT0 != 32'hFFFF_FFFF)) CNT0 <= CNT0 + 32'd1;
      if (r1 && bus.V1 && (CNT1 != 32'hFFFF_FFFF)) CNT1 <= CNT1 + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: BURST=4 instance plus a BURST=1 instance,
// output beats scored against a queue of expected words.
module tb_mux2_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  mux2_arbiter_if #(.N(16)) a_if ();
  mux2_arbiter_if #(.N(16)) b_if ();

`ifdef MUX2_ARBITER_STATS_EN
  logic [31:0] cnt0a, cnt1a, cnt0b, cnt1b;
`endif

  mux2_arbiter #(.N(16), .BURST(4)) dut_a (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (a_if.slave)
`ifdef MUX2_ARBITER_STATS_EN
    ,
    .CNT0    (cnt0a),
    .CNT1    (cnt1a)
`endif
  );

  mux2_arbiter #(.N(16), .BURST(1)) dut_b (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (b_if.slave)
`ifdef MUX2_ARBITER_STATS_EN
    ,
    .CNT0    (cnt0b),
    .CNT1    (cnt1b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (a_if.YV && a_if.YR) begin
      e = (qa.size() > 0) ? {16'h0, qa.pop_front()} : 32'hdead_beef;
      check("a_beat", {16'h0, a_if.Y}, e);
    end
    if (b_if.YV && b_if.YR) begin
      e = (qb.size() > 0) ? {16'h0, qb.pop_front()} : 32'hdead_beef;
      check("b_beat", {16'h0, b_if.Y}, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) tick();
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    tick();
    tick();
    check("idle_yv_a", {31'h0, a_if.YV}, 0);
  endtask

  task automatic do_reset();
    a_if.V0 = 1'b0; a_if.V1 = 1'b0; a_if.YR = 1'b1;
    b_if.V0 = 1'b0; b_if.V1 = 1'b0; b_if.YR = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_a(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) qa.push_back(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset applied with both requesters asserting
    rst_n = 1'b0;
    a_if.D0 = 16'h1111; a_if.D1 = 16'h2222; a_if.V0 = 1'b1; a_if.V1 = 1'b1; a_if.YR = 1'b1;
    b_if.D0 = 16'h0101; b_if.D1 = 16'h3456; b_if.V0 = 1'b0; b_if.V1 = 1'b0; b_if.YR = 1'b1;
    #2;
    check("rst_y", {16'h0, a_if.Y}, 32'h0);
    check("rst_yv", {31'h0, a_if.YV}, 0);
    check("rst_s", {31'h0, a_if.S}, 0);
    check("rst_r0", {31'h0, a_if.R0}, 0);
    check("rst_r1", {31'h0, a_if.R1}, 0);
    tick();
    tick();
    check("rst_hold_yv", {31'h0, a_if.YV}, 0);
    check("rst_hold_r", {30'h0, a_if.R1, a_if.R0}, 0);
    do_reset();

    // single requester
    a_if.V0 = 1'b1; a_if.D0 = 16'h8000; a_if.YR = 1'b1;
    push_a(16'h8000, 1);
    tick();
    check("t2_r0", {31'h0, a_if.R0}, 1);
    check("t2_s_c1", {31'h0, a_if.S}, 0);
    check("t2_yv_c1", {31'h0, a_if.YV}, 0);
    tick();
    a_if.V0 = 1'b0;
    check("t2_yv", {31'h0, a_if.YV}, 1);
    check("t2_y", {16'h0, a_if.Y}, 32'h8000);
    check("t2_s_c2", {31'h0, a_if.S}, 0);
    drain();
    do_reset();

    // contention with BURST=4
    a_if.V0 = 1'b1; a_if.V1 = 1'b1; a_if.D0 = 16'h234f; a_if.D1 = 16'hfeac;
    push_a(16'h234f, 4); push_a(16'hfeac, 4); push_a(16'h234f, 4);
    for (int k = 1; k <= 13; k++) begin
      tick();
      check("t3_s", {31'h0, a_if.S}, ((k - 1) / 4) % 2);
      if (k >= 2) check("t3_nobubble", {31'h0, a_if.YV}, 1);
    end
    a_if.V0 = 1'b0; a_if.V1 = 1'b0;
    drain();
`ifdef MUX2_ARBITER_STATS_EN
    check("t3_cnt0", cnt0a, 8);
    check("t3_cnt1", cnt1a, 4);
`endif
    do_reset();

    // backpressure after the first beat
    a_if.V0 = 1'b1; a_if.V1 = 1'b1;
    push_a(16'h234f, 4); push_a(16'hfeac, 4);
    tick();
    check("t4_r0", {31'h0, a_if.R0}, 1);
    tick();
    a_if.YR = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_r0_bp", {31'h0, a_if.R0}, 0);
      check("t4_r1_bp", {31'h0, a_if.R1}, 0);
      check("t4_yv_bp", {31'h0, a_if.YV}, 1);
      check("t4_y_bp", {16'h0, a_if.Y}, 32'h234f);
      check("t4_s_bp", {31'h0, a_if.S}, 0);
    end
    a_if.YR = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("t4_s", {31'h0, a_if.S}, (k >= 3 && k <= 6) ? 1 : 0);
    end
    a_if.V0 = 1'b0; a_if.V1 = 1'b0;
    drain();

    // BURST=1 alternation
    b_if.V0 = 1'b1; b_if.V1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      qb.push_back(16'h0101);
      qb.push_back(16'h3456);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("t5_s", {31'h0, b_if.S}, (k - 1) % 2);
    end
    b_if.V0 = 1'b0; b_if.V1 = 1'b0;
    drain();
    do_reset();

    // reset in the middle of a requester-1 burst
    a_if.V1 = 1'b1; a_if.D1 = 16'hfeac; a_if.D0 = 16'h234f;
    push_a(16'hfeac, 1);
    tick();
    check("t6_s_g1", {31'h0, a_if.S}, 1);
    tick();
    tick();
    check("t6_y_pre", {16'h0, a_if.Y}, 32'hfeac);
    check("t6_yv_pre", {31'h0, a_if.YV}, 1);
`ifdef MUX2_ARBITER_STATS_EN
    check("t6_cnt1_pre", cnt1a, 2);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_y_rst", {16'h0, a_if.Y}, 32'h0);
    check("t6_yv_rst", {31'h0, a_if.YV}, 0);
    check("t6_s_rst", {31'h0, a_if.S}, 0);
    check("t6_r_rst", {30'h0, a_if.R1, a_if.R0}, 0);
    check("t6_q_empty", qa.size(), 0);
`ifdef MUX2_ARBITER_STATS_EN
    check("t6_cnt0_rst", cnt0a, 0);
    check("t6_cnt1_rst", cnt1a, 0);
`endif
    a_if.V0 = 1'b1; a_if.V1 = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    push_a(16'h234f, 2);
    tick();
    check("t6_s_after", {31'h0, a_if.S}, 0);
    check("t6_r0_after", {31'h0, a_if.R0}, 1);
    check("t6_r1_after", {31'h0, a_if.R1}, 0);
    tick();
    tick();
    a_if.V0 = 1'b0; a_if.V1 = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Round-robin arbiter that shares one mux2 datapath (N-bit, 2:1) between two valid/ready requesters.
- Grants one requester for a burst of up to BURST beats and drives the mux select.
- Registers the selected word into a single-entry output stage with valid/ready backpressure.
- Sits in front of any shared operand bus fed through mux2, e.g. ALU operand or memory write-data sharing.

Parameters:
- N, 16, data width of D0/D1/Y in bits.
- BURST, 4, maximum beats per grant (>=1); beat counter width $clog2(BURST+1).

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- D0  input  N  requester 0 data.
- V0  input  1  requester 0 valid.
- R0  output  1  requester 0 ready.
- D1  input  N  requester 1 data.
- V1  input  1  requester 1 valid.
- R1  output  1  requester 1 ready.
- Y  output  N  registered output data.
- YV  output  1  output valid.
- YR  input  1  output ready from downstream.
- S  output  1  registered mux select: 0 = requester 0, 1 = requester 1.

Behaviour:
- Clocking/reset: one clock (CLOCK); reset asynchronous, active-low (RESET_N).
- Reset values: state=IDLE, PRIO=0, beat count=0, S=0, Y=0, YV=0, R0=R1=0. Reset mid-burst drops any held output word immediately.
- Data path: datapath word = S ? D1 : D0, built from an internal mux2 instance driven by S.
- accept = !YV | YR (output stage empty or draining this cycle).
- Ready signals (combinational): R0 = (state==GNT0) & accept; R1 = (state==GNT1) & accept. Both are 0 in IDLE.
- Transfer: occurs on Vx & Rx. Next edge: Y<=Dx, YV<=1, count++.
- Output drain: if YV & YR and no transfer, YV<=0. Y holds its value while YV & !YR.
- pick(p), priority p:
  - if Vp -> GNTp;
  - else if V(!p) -> GNT(!p);
  - else IDLE.
- State IDLE: next = pick(PRIO); count<=0. S<=1 only when entering GNT1, else 0.
- State GNTx, end-of-grant when:
  - a transfer happens with count==BURST-1, or
  - Vx==0.
- On end-of-grant: PRIO<=!x; next=pick(!x); count<=0.
  - Current requester is re-granted with no idle cycle if it is the only one still valid after its burst completes.
- Otherwise stay in GNTx.
- Direct GNT0<->GNT1 switch inserts no bubble, giving full throughput with both valid.
- Latency: Vx rising in IDLE gives Rx one cycle later; Y/YV one cycle after the transfer (2 cycles total).
- Backpressure: YR=0 with YV=1 forces R0=R1=0; count frozen; grant held. Burst boundary is counted only on transfers.
- Vx dropping without a transfer is legal: it ends the grant as above.
- S changes only on state transitions and always equals the granted side.

Optional Feature:
- Macro: MUX2_ARBITER_STATS_EN.
- Defined:
  - adds outputs CNT0, CNT1 (32-bit each), counting completed transfers per requester;
  - both reset to 0 on RESET_N low;
  - saturate at 32'hFFFFFFFF;
  - counters update on the same edge as Y.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
1. Reset: RESET_N=0 with V0=V1=1 -> Y=16'h0000, YV=0, S=0, R0=R1=0 immediately (async); held until release.
2. Single requester: V0=1, D0=16'h8000, YR=1 from IDLE -> R0=1 on cycle 1; YV=1, Y=16'h8000 on cycle 2; S=0 throughout.
3. Contention, BURST=4, YR=1:
   - V0=V1=1, D0=16'h234f, D1=16'hfeac -> Y=234f for 4 beats, then feac for 4 beats, repeating.
   - S toggles every 4 cycles; no bubble cycles; PRIO starts at 0.
4. Backpressure: after the first beat Y=16'h234f, drive YR=0 for 5 cycles -> R0=0, Y/YV stable, count frozen. On YR=1, 3 more requester-0 beats, then grant passes to requester 1.
5. BURST=1, both valid -> Y alternates 16'h0101, 16'h3456 every cycle; S alternates 0,1.
6. Mid-burst reset: RESET_N low after 2 beats of requester 1 -> outputs to reset values asynchronously. After release with both valid, requester 0 is granted first (PRIO=0). With MUX2_ARBITER_STATS_EN defined, CNT0=CNT1=0 after reset.
